// File: rtl/vblank_sched_pkg.sv
// Shared types and helpers for the vertical-blank update scheduler.
// Optional round-robin arbitration is enabled by VBLANK_SCHED_RR_EN.
package vblank_sched_pkg;

  localparam int NREQ_MAX = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    GRANT
  } state_t;

  function automatic logic [NREQ_MAX-1:0] onehot(
    input logic [IDX_W-1:0] idx
  );
    return NREQ_MAX'(1) << idx;
  endfunction

endpackage

// File: rtl/vblank_sched_pick.sv
// Priority search over pending requesters, starting at a given index
// and ascending with wrap.
module vblank_sched_pick
  import vblank_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  pend,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int j;

  // Walk from the farthest index back so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= NREQ) j = j - NREQ;
      if (pend[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/vblank_sched.sv
// Grants one game-logic update slot at a time inside vertical blank.
// Define VBLANK_SCHED_RR_EN for per-frame rotating priority.
module vblank_sched
  import vblank_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_SLOT = 4096,
  parameter int FCNT_W   = 16
) (
  input  logic              px_clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              activevideo,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   done,
  input  logic              clr_flags,
  output logic [NREQ-1:0]   gnt,
  output logic              frame_start,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_count,
  output logic              overrun,
  output logic [NREQ-1:0]   timeout
);

  localparam int SW = $clog2(MAX_SLOT);
  localparam logic [SW-1:0] SLOT_LAST = SW'(MAX_SLOT - 1);

  state_t            state_q, state_d;
  logic              vsync_q;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              frame_start_q, frame_start_d;
  logic              busy_q, busy_d;
  logic [FCNT_W-1:0] frame_count_q, frame_count_d;
  logic              overrun_q, overrun_d;
  logic [NREQ-1:0]   timeout_q, timeout_d;
  logic [NREQ-1:0]   pend_q, pend_d;
  logic [SW-1:0]     slot_cnt_q, slot_cnt_d;

  logic [IDX_W-1:0]    pick_start;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic [NREQ_MAX-1:0] pick_oh;

  vblank_sched_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .pend (pend_q),
    .start(pick_start),
    .found(pick_found),
    .idx  (pick_idx)
  );

  assign pick_oh = onehot(pick_idx);

  if (NREQ < NREQ_MAX) begin : g_pad
    logic unused_oh;
    assign unused_oh = |pick_oh[NREQ_MAX-1:NREQ];
  end

`ifdef VBLANK_SCHED_RR_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // Rotate after the first scan of the frame has used the old pointer.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (frame_start_q) begin
      if (rr_ptr_q == IDX_W'(NREQ - 1)) rr_ptr_d = '0;
      else rr_ptr_d = rr_ptr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge px_clk) begin
    if (reset) rr_ptr_q <= '0;
    else rr_ptr_q <= rr_ptr_d;
  end

  assign pick_start = rr_ptr_q;
`else
  assign pick_start = '0;
`endif

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    frame_start_d = 1'b0;
    busy_d        = busy_q;
    frame_count_d = frame_count_q;
    pend_d        = pend_q;
    slot_cnt_d    = slot_cnt_q;
    overrun_d     = overrun_q & ~clr_flags;
    timeout_d     = timeout_q & ~{NREQ{clr_flags}};
    unique case (state_q)
      IDLE: begin
        if (vsync_q && !vsync) begin
          frame_start_d = 1'b1;
          busy_d        = 1'b1;
          frame_count_d = frame_count_q + FCNT_W'(1);
          pend_d        = req;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        if (activevideo && |pend_q) begin
          overrun_d = 1'b1;
          pend_d    = '0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else if (!pick_found) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gnt_d      = pick_oh[NREQ-1:0];
          pend_d     = pend_q & ~pick_oh[NREQ-1:0];
          slot_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (activevideo) begin
          gnt_d     = '0;
          overrun_d = 1'b1;
          pend_d    = '0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else if (|(done & gnt_q)) begin
          gnt_d   = '0;
          state_d = SCAN;
        end else if (slot_cnt_q == SLOT_LAST) begin
          gnt_d     = '0;
          timeout_d = timeout_d | gnt_q;
          state_d   = SCAN;
        end else begin
          slot_cnt_d = slot_cnt_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      vsync_q       <= 1'b0;
      gnt_q         <= '0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      timeout_q     <= '0;
      pend_q        <= '0;
      slot_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync;
      gnt_q         <= gnt_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
      pend_q        <= pend_d;
      slot_cnt_q    <= slot_cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_vblank_sched.sv
// Directed bench for vblank_sched: table of single-frame vectors
// plus hand sequences for reset, flag clearing and frame rotation.
module tb_vblank_sched;

  localparam int NREQ = 4;
  localparam int MAX_SLOT = 8;
  localparam int FCNT_W = 4;
  localparam int NEVER = 255;

  logic              px_clk = 1'b0;
  logic              reset = 1'b1;
  logic              vsync = 1'b1;
  logic              activevideo = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   done = '0;
  logic              clr_flags = 1'b0;
  logic [NREQ-1:0]   gnt;
  logic              frame_start;
  logic              busy;
  logic [FCNT_W-1:0] frame_count;
  logic              overrun;
  logic [NREQ-1:0]   timeout;

  int n_cmp = 0;
  int n_bad = 0;

  vblank_sched #(
    .NREQ(NREQ),
    .MAX_SLOT(MAX_SLOT),
    .FCNT_W(FCNT_W)
  ) dut (
    .px_clk(px_clk),
    .reset(reset),
    .vsync(vsync),
    .activevideo(activevideo),
    .req(req),
    .done(done),
    .clr_flags(clr_flags),
    .gnt(gnt),
    .frame_start(frame_start),
    .busy(busy),
    .frame_count(frame_count),
    .overrun(overrun),
    .timeout(timeout)
  );

  always #5 px_clk = ~px_clk;

  typedef struct {
    logic [3:0]  req;
    int          dly;
    int          win;
    logic [15:0] log;
    int          n;
    int          hold;
    logic        ovr;
    logic [3:0]  to;
    int          endc;
  } vec_t;

  vec_t tbl[11];

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vsync = 1'b1;
    activevideo = 1'b0;
    req = '0;
    done = '0;
    clr_flags = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One vblank window: edge at cycle 0, done pulsed dly cycles after
  // each new grant, activevideo raised after cycle win.
  task automatic run_frame(input logic [3:0] r, input int dly,
                           input int win, output logic [15:0] log,
                           output int n, output int hold0,
                           output int endc);
    int c;
    int dcnt;
    logic [3:0] prev;
    logic [3:0] dval;
    req = r;
    activevideo = 1'b0;
    vsync = 1'b1;
    done = '0;
    tick();
    tick();
    vsync = 1'b0;
    tick();
    chk("frame_start", {31'd0, frame_start}, 32'd1);
    req = ~r;
    log = '0;
    n = 0;
    hold0 = 0;
    prev = '0;
    dval = '0;
    dcnt = 0;
    c = 0;
    if (win == 0) activevideo = 1'b1;
    do begin
      tick();
      c++;
      done = '0;
      if (gnt != 0 && gnt != prev) begin
        log = {log[11:0], gnt};
        n++;
        dcnt = dly;
        dval = gnt;
      end
      if (n == 1 && gnt != 0) hold0++;
      prev = gnt;
      if (dval != 0 && dly != NEVER) begin
        if (dcnt == 0) begin
          done = dval;
          dval = '0;
        end else begin
          dcnt--;
        end
      end
      if (c == 2) vsync = 1'b1;
      if (c == win) activevideo = 1'b1;
    end while (busy && c < 300);
    if (busy) chk("busy_bound", {31'd0, busy}, 32'd0);
    done = '0;
    endc = c;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] lg;
    int n;
    int h;
    int e;
    logic [3:0] exp_first;

    tbl[0]  = '{4'b0101, 3,     200, 16'h0014, 2, 4, 1'b0, 4'b0000, 11};
    tbl[1]  = '{4'b0010, NEVER, 200, 16'h0002, 1, 8, 1'b0, 4'b0010, 10};
    tbl[2]  = '{4'b0010, 7,     200, 16'h0002, 1, 8, 1'b0, 4'b0000, 10};
    tbl[3]  = '{4'b1111, 5,     24,  16'h1248, 4, 6, 1'b1, 4'b0000, 25};
    tbl[4]  = '{4'b0000, 3,     200, 16'h0000, 0, 0, 1'b0, 4'b0000, 1};
    tbl[5]  = '{4'b1100, 3,     0,   16'h0000, 0, 0, 1'b1, 4'b0000, 1};
    tbl[6]  = '{4'b0000, 3,     0,   16'h0000, 0, 0, 1'b0, 4'b0000, 1};
    tbl[7]  = '{4'b1000, 0,     200, 16'h0008, 1, 1, 1'b0, 4'b0000, 3};
    tbl[8]  = '{4'b0110, 8,     200, 16'h0024, 2, 8, 1'b0, 4'b0110, 19};
    tbl[9]  = '{4'b0011, 0,     2,   16'h0001, 1, 1, 1'b1, 4'b0000, 3};
    tbl[10] = '{4'b0001, 0,     2,   16'h0001, 1, 1, 1'b0, 4'b0000, 3};

    do_reset();
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    chk("rst_fc", {28'd0, frame_count}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_to", {28'd0, timeout}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_reset();
      run_frame(tbl[i].req, tbl[i].dly, tbl[i].win, lg, n, h, e);
      chk($sformatf("v%0d_log", i), {16'd0, lg}, {16'd0, tbl[i].log});
      chk($sformatf("v%0d_n", i), n, tbl[i].n);
      chk($sformatf("v%0d_hold", i), h, tbl[i].hold);
      chk($sformatf("v%0d_end", i), e, tbl[i].endc);
      chk($sformatf("v%0d_ovr", i), {31'd0, overrun},
          {31'd0, tbl[i].ovr});
      chk($sformatf("v%0d_to", i), {28'd0, timeout}, {28'd0, tbl[i].to});
      chk($sformatf("v%0d_gnt", i), {28'd0, gnt}, 32'd0);
      chk($sformatf("v%0d_fc", i), {28'd0, frame_count}, 32'd1);
    end

    // Aborted frame leaves nothing pending for the next one.
    do_reset();
    run_frame(4'b1111, 5, 24, lg, n, h, e);
    run_frame(4'b0000, 0, 200, lg, n, h, e);
    chk("after_abort_n", n, 0);
    chk("after_abort_fc", {28'd0, frame_count}, 32'd2);

    // Reset while a grant is held.
    do_reset();
    req = 4'b0001;
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    chk("pre_rst_gnt", {28'd0, gnt}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_gnt", {28'd0, gnt}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_fc", {28'd0, frame_count}, 32'd0);
    reset = 1'b0;
    req = '0;
    tick();

    // clr_flags coincident with a timeout: the set wins.
    do_reset();
    req = 4'b0010;
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) tick();
    chk("to_pre", {28'd0, timeout}, 32'd0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("to_setwins", {28'd0, timeout}, 32'd2);
    chk("to_gnt_off", {28'd0, gnt}, 32'd0);
    tick();
    chk("to_busy_off", {31'd0, busy}, 32'd0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("to_cleared", {28'd0, timeout}, 32'd0);

    run_frame(4'b1100, 3, 0, lg, n, h, e);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Sixteen frames: first grant rotation and frame counter wrap.
    do_reset();
    for (int f = 1; f <= 16; f++) begin
`ifdef VBLANK_SCHED_RR_EN
      exp_first = 4'b0001 << ((f - 1) % 4);
`else
      exp_first = 4'b0001;
`endif
      run_frame(4'b1111, 0, 200, lg, n, h, e);
      chk($sformatf("rr_f%0d_first", f), {28'd0, lg[15:12]},
          {28'd0, exp_first});
    end
    chk("fc_wrap", {28'd0, frame_count}, 32'd0);
    chk("rr_ovr", {31'd0, overrun}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
